// File: rtl/squared_magnitude_if.sv
// Handshake and result bundle between an upstream vector source, squared_magnitude
// and the downstream SquareRoot operand/start inputs.
interface squared_magnitude_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_x;
  logic signed [IN_W-1:0]  in_y;
  logic signed [IN_W-1:0]  in_z;
  logic [OUT_W-1:0]        sq_out;
  logic                    sq_start;
  logic                    busy;

  modport master (
    output in_valid, in_x, in_y, in_z,
    input  in_ready, sq_out, sq_start, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, in_z,
    output in_ready, sq_out, sq_start, busy
  );
endinterface

// File: rtl/squared_magnitude.sv
// Sequential x^2 + y^2 + z^2 over one shared multiplier, handing a 12-bit result and a
// start pulse to SquareRoot. Define SQMAG_SATURATE_EN to saturate overflow instead of wrapping.
//
// state | meaning
// IDLE  | ready for a vector; captures x, y, z on accept
// SQX   | acc <= x*x
// SQY   | acc <= acc + y*y
// SQZ   | acc <= acc + z*z
// DONE  | sq_out <= fit(acc), sq_start pulse registered
module squared_magnitude #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
) (
  input logic            clk,
  input logic            rst_,
  squared_magnitude_if.slave bus
);

  localparam int ACC_W = 2 * IN_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQX  = 3'd1,
    SQY  = 3'd2,
    SQZ  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic signed [IN_W-1:0]  x_q;
  logic signed [IN_W-1:0]  y_q;
  logic signed [IN_W-1:0]  z_q;
  logic signed [IN_W-1:0]  mul_op;
  logic signed [ACC_W-1:0] prod;
  logic [ACC_W-1:0]        prod_u;
  logic [ACC_W-1:0]        acc;
  logic [OUT_W-1:0]        fit_val;
  logic                    accept;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b1;
    mul_op       = x_q;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) begin
          state_nxt = SQX;
        end
      end
      SQX: begin
        mul_op    = x_q;
        state_nxt = SQY;
      end
      SQY: begin
        mul_op    = y_q;
        state_nxt = SQZ;
      end
      SQZ: begin
        mul_op    = z_q;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept = bus.in_valid && (state == IDLE);

  // A square is never negative, so the signed product can feed the unsigned accumulator as-is.
  assign prod   = ACC_W'(mul_op) * ACC_W'(mul_op);
  assign prod_u = prod;

  if (OUT_W >= ACC_W) begin : g_no_ovf
    assign fit_val = OUT_W'(acc);
  end else begin : g_fit
`ifdef SQMAG_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);
    assign fit_val = (acc > SAT_MAX) ? {OUT_W{1'b1}} : acc[OUT_W-1:0];
`else
    assign fit_val = acc[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      acc          <= '0;
      bus.sq_out   <= '0;
      bus.sq_start <= 1'b0;
    end else begin
      bus.sq_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x_q <= bus.in_x;
            y_q <= bus.in_y;
            z_q <= bus.in_z;
            acc <= '0;
          end
        end
        SQX: begin
          acc <= prod_u;
        end
        SQY, SQZ: begin
          acc <= acc + prod_u;
        end
        DONE: begin
          bus.sq_out   <= fit_val;
          bus.sq_start <= 1'b1;
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_squared_magnitude.sv
// Scoreboard bench for squared_magnitude: a driver pushes hand-computed results on accept,
// a monitor pops them on each sq_start and also checks pulse width, latency and hold.
module tb_squared_magnitude;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  squared_magnitude_if #(.IN_W(8), .OUT_W(12)) bus ();

  squared_magnitude #(.IN_W(8), .OUT_W(12)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  typedef struct {
    int x;
    int y;
    int z;
    int wrap_v;
    int sat_v;
  } vec_t;

  vec_t vecs [13] = '{
    '{   3,    4,    0,   25,   25},
    '{ -32,  -32,  -32, 3072, 3072},
    '{ 127,  127,  127, 3331, 4095},
    '{-128, -128, -128,    0, 4095},
    '{   1,    2,    3,   14,   14},
    '{  -5,    6,   -7,  110,  110},
    '{  10,  -20,   30, 1400, 1400},
    '{   0,    0,   -1,    1,    1},
    '{  64,    0,    0,    0, 4095},
    '{  63,  -64,    0, 3969, 4095},
    '{-128,    0,    0,    0, 4095},
    '{   0,    0,    0,    0,    0},
    '{  -1,   -1,   -1,    3,    3}
  };

  int n_pass  = 0;
  int n_total = 0;
  int exp_q [$];
  int acc_q [$];

  function automatic int pick(input vec_t v);
`ifdef SQMAG_SATURATE_EN
    return v.sat_v;
`else
    return v.wrap_v;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Offer v, wait (bounded) for acceptance, then scramble the inputs while keeping in_valid up.
  task automatic send(input vec_t v, output int acc_c);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x = 8'(v.x);
    bus.in_y = 8'(v.y);
    bus.in_z = 8'(v.z);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, required 1", waited);
      acc_c = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc_c = cyc;
    exp_q.push_back(pick(v));
    acc_q.push_back(cyc);
    bus.in_x = 8'h55;
    bus.in_y = 8'hAA;
    bus.in_z = 8'h7F;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  logic [11:0] last_out = '0;
  bit          prev_start = 1'b0;
  int          mon_e;
  int          mon_a;

  always @(negedge clk) begin
    #1;
    if (rst_) begin
      last_out   = '0;
      prev_start = 1'b0;
    end else begin
      if (prev_start) chk("start_width", int'(bus.sq_start), 0);
      if (bus.sq_start) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_start: sq_start=1 with no pending result, required 0");
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          chk("sq_out", int'(bus.sq_out), mon_e);
          chk("latency", cyc - mon_a, 4);
          last_out = 12'(mon_e);
        end
      end else begin
        chk("hold", int'(bus.sq_out), int'(last_out));
      end
      prev_start = bus.sq_start;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int prev;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.in_z = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_sq_out", int'(bus.sq_out), 0);
    chk("rst_sq_start", int'(bus.sq_start), 0);
    @(negedge clk);
    rst_ = 1'b0;

    // single vector with handshake timing
    send(vecs[0], a);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_ready", int'(bus.in_ready), 0);
      chk("busy_flag", int'(bus.busy), 1);
    end
    @(negedge clk);
    chk("ready_back", int'(bus.in_ready), 1);
    chk("busy_back", int'(bus.busy), 0);
    drain();

    // in_valid held high, back-to-back vectors
    prev = -1;
    for (int i = 1; i < 13; i++) begin
      send(vecs[i], a);
      if (prev >= 0 && a >= 0) chk("accept_spacing", a - prev, 5);
      prev = a;
    end
    bus.in_valid = 1'b0;
    drain();

    // asynchronous reset while in SQY
    send(vecs[5], a);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_sq_out", int'(bus.sq_out), 0);
    chk("abort_sq_start", int'(bus.sq_start), 0);
    repeat (2) @(negedge clk);
    rst_ = 1'b0;
    repeat (8) @(negedge clk);
    send(vecs[6], a);
    bus.in_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
